// File: rtl/stack_op_sequencer.sv
// rtl/stack_op_sequencer.sv - multi-cycle PUSH/POP sequencer driving the ESP register and stack memory
//
// Purpose:
//   Accepts push/pop requests from decode/control, computes the new stack
//   pointer (driven on alu_result_bus with read_or_write=4'h1 for one cycle),
//   and performs the matching 32-bit memory write (push) or read (pop) with
//   wait-state support through mem_ready.
//
// Optional feature macro: STACK_BOUNDS_CHECK_EN
//   Defined   : pushes below STACK_LIMIT / pops at or above STACK_BASE are
//               rejected at accept, skip straight to DONE and raise fault.
//   Undefined : no checks, fault tied 0, pointer arithmetic wraps mod 2^32.
//
// Ports:
//   clock_4        in   1  sequencer clock, posedge
//   reset          in   1  asynchronous active-high reset
//   esp            in  32  current stack pointer
//   push_req       in   1  start push (sampled in IDLE only, wins over pop)
//   pop_req        in   1  start pop (sampled in IDLE only)
//   push_data      in  32  value to push, captured at accept
//   mem_rdata      in  32  memory read data, valid with mem_ready
//   mem_ready      in   1  memory completes current access this cycle
//   mem_addr       out 32  memory address
//   mem_wdata      out 32  memory write data
//   mem_we         out  1  memory write strobe
//   mem_re         out  1  memory read strobe
//   alu_result_bus out 32  new ESP value
//   read_or_write  out  4  4'h1 = ESP write, 4'h0 = none
//   pop_data       out 32  last popped value
//   busy           out  1  accept through DONE inclusive
//   done           out  1  one-cycle completion pulse
//   fault          out  1  bounds violation (with done)

module stack_op_sequencer #(
  parameter logic [31:0] STACK_BASE  = 32'h0000_1000,
  parameter logic [31:0] STACK_LIMIT = 32'h0000_0800
) (
  input  logic        clock_4,
  input  logic        reset,
  input  logic [31:0] esp,
  input  logic        push_req,
  input  logic        pop_req,
  input  logic [31:0] push_data,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  output logic [31:0] alu_result_bus,
  output logic [3:0]  read_or_write,
  output logic [31:0] pop_data,
  output logic        busy,
  output logic        done,
  output logic        fault
);

`ifdef STACK_BOUNDS_CHECK_EN
  localparam logic BOUNDS_EN = 1'b1;
`else
  localparam logic BOUNDS_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PUSH_DEC = 3'd1,
    S_PUSH_WR  = 3'd2,
    S_POP_RD   = 3'd3,
    S_POP_INC  = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  state_t      r_state, w_state_nxt;

  logic [31:0] r_esp, r_data;
  logic [31:0] r_mem_addr, r_mem_wdata, r_alu, r_pop_data;
  logic        r_mem_we, r_mem_re, r_busy, r_done, r_fault;
  logic [3:0]  r_rw;

  logic [31:0] w_mem_addr, w_mem_wdata, w_alu, w_pop_data;
  logic        w_mem_we, w_mem_re, w_busy, w_done, w_fault;
  logic [3:0]  w_rw;
  logic        w_capture;
  logic        w_push_viol, w_pop_viol;
  logic [31:0] w_esp_dec, w_esp_inc;

  // 33-bit compare so esp < 4 counts as below the limit instead of wrapping.
  assign w_push_viol = BOUNDS_EN && ({1'b0, esp} < ({1'b0, STACK_LIMIT} + 33'd4));
  assign w_pop_viol  = BOUNDS_EN && (esp >= STACK_BASE);
  assign w_esp_dec   = r_esp - 32'd4;
  assign w_esp_inc   = r_esp + 32'd4;

  always_ff @(posedge clock_4 or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Outputs are registered from the state being entered, so every output
  // register shows the phase that the state register holds.
  always_comb begin
    w_state_nxt = r_state;
    w_mem_addr  = r_mem_addr;
    w_mem_wdata = r_mem_wdata;
    w_alu       = r_alu;
    w_pop_data  = r_pop_data;
    w_mem_we    = 1'b0;
    w_mem_re    = 1'b0;
    w_rw        = 4'h0;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    w_fault     = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (push_req) begin
          w_capture = 1'b1;
          w_busy    = 1'b1;
          if (w_push_viol) begin
            w_state_nxt = S_DONE;
            w_done      = 1'b1;
            w_fault     = 1'b1;
          end else begin
            w_state_nxt = S_PUSH_DEC;
            w_alu       = esp - 32'd4;
            w_rw        = 4'h1;
          end
        end else if (pop_req) begin
          w_capture = 1'b1;
          w_busy    = 1'b1;
          if (w_pop_viol) begin
            w_state_nxt = S_DONE;
            w_done      = 1'b1;
            w_fault     = 1'b1;
          end else begin
            w_state_nxt = S_POP_RD;
            w_mem_addr  = esp;
            w_mem_re    = 1'b1;
          end
        end
      end
      S_PUSH_DEC: begin
        w_state_nxt = S_PUSH_WR;
        w_busy      = 1'b1;
        w_mem_addr  = w_esp_dec;
        w_mem_wdata = r_data;
        w_mem_we    = 1'b1;
      end
      S_PUSH_WR: begin
        w_busy = 1'b1;
        if (mem_ready) begin
          w_state_nxt = S_DONE;
          w_done      = 1'b1;
        end else begin
          w_mem_we = 1'b1;
        end
      end
      S_POP_RD: begin
        w_busy = 1'b1;
        if (mem_ready) begin
          w_state_nxt = S_POP_INC;
          w_pop_data  = mem_rdata;
          w_alu       = w_esp_inc;
          w_rw        = 4'h1;
        end else begin
          w_mem_re = 1'b1;
        end
      end
      S_POP_INC: begin
        w_state_nxt = S_DONE;
        w_busy      = 1'b1;
        w_done      = 1'b1;
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock_4 or posedge reset) begin
    if (reset) begin
      r_esp       <= 32'h0;
      r_data      <= 32'h0;
      r_mem_addr  <= 32'h0;
      r_mem_wdata <= 32'h0;
      r_alu       <= 32'h0;
      r_pop_data  <= 32'h0;
      r_mem_we    <= 1'b0;
      r_mem_re    <= 1'b0;
      r_rw        <= 4'h0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_fault     <= 1'b0;
    end else begin
      if (w_capture) begin
        r_esp  <= esp;
        r_data <= push_data;
      end
      r_mem_addr  <= w_mem_addr;
      r_mem_wdata <= w_mem_wdata;
      r_alu       <= w_alu;
      r_pop_data  <= w_pop_data;
      r_mem_we    <= w_mem_we;
      r_mem_re    <= w_mem_re;
      r_rw        <= w_rw;
      r_busy      <= w_busy;
      r_done      <= w_done;
      r_fault     <= w_fault;
    end
  end

  assign mem_addr       = r_mem_addr;
  assign mem_wdata      = r_mem_wdata;
  assign mem_we         = r_mem_we;
  assign mem_re         = r_mem_re;
  assign alu_result_bus = r_alu;
  assign read_or_write  = r_rw;
  assign pop_data       = r_pop_data;
  assign busy           = r_busy;
  assign done           = r_done;
  assign fault          = r_fault;

endmodule

// File: tb/tb_stack_op_sequencer.sv
// tb/tb_stack_op_sequencer.sv - directed self-checking bench for stack_op_sequencer

module tb_stack_op_sequencer;

  logic        clock_4;
  logic        reset;
  logic [31:0] esp;
  logic        push_req;
  logic        pop_req;
  logic [31:0] push_data;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [31:0] alu_result_bus;
  logic [3:0]  read_or_write;
  logic [31:0] pop_data;
  logic        busy;
  logic        done;
  logic        fault;

  int n_cmp;
  int n_bad;

  stack_op_sequencer dut (
    .clock_4        (clock_4),
    .reset          (reset),
    .esp            (esp),
    .push_req       (push_req),
    .pop_req        (pop_req),
    .push_data      (push_data),
    .mem_rdata      (mem_rdata),
    .mem_ready      (mem_ready),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_we         (mem_we),
    .mem_re         (mem_re),
    .alu_result_bus (alu_result_bus),
    .read_or_write  (read_or_write),
    .pop_data       (pop_data),
    .busy           (busy),
    .done           (done),
    .fault          (fault)
  );

  initial clock_4 = 1'b0;
  always #5 clock_4 = ~clock_4;

  task automatic tick();
    @(posedge clock_4);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    esp = 32'h0; push_req = 1'b0; pop_req = 1'b0;
    push_data = 32'h0; mem_rdata = 32'h0; mem_ready = 1'b0;
    tick(); tick();
    n_cmp++;
    if ({mem_we, mem_re, busy, done, fault, read_or_write} !== 9'h0) begin
      n_bad++; $display("FAIL reset_ctrl got %b want 0", {mem_we, mem_re, busy, done, fault, read_or_write});
    end
    n_cmp++;
    if ({mem_addr, mem_wdata, alu_result_bus, pop_data} !== 128'h0) begin
      n_bad++; $display("FAIL reset_data got %h want 0", {mem_addr, mem_wdata, alu_result_bus, pop_data});
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_push();
    esp = 32'h0000_1000; push_data = 32'hDEAD_BEEF; mem_ready = 1'b1; push_req = 1'b1;
    tick();
    push_req = 1'b0;
    n_cmp++;
    if (read_or_write !== 4'h1 || alu_result_bus !== 32'h0FFC || busy !== 1'b1 || mem_we !== 1'b0) begin
      n_bad++; $display("FAIL push_dec rw=%h alu=%h busy=%b we=%b want 1/00000ffc/1/0", read_or_write, alu_result_bus, busy, mem_we);
    end
    tick();
    n_cmp++;
    if (read_or_write !== 4'h0 || mem_we !== 1'b1 || mem_addr !== 32'h0FFC || mem_wdata !== 32'hDEAD_BEEF) begin
      n_bad++; $display("FAIL push_wr rw=%h we=%b addr=%h wdata=%h want 0/1/00000ffc/deadbeef", read_or_write, mem_we, mem_addr, mem_wdata);
    end
    tick();
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b1 || mem_we !== 1'b0 || fault !== 1'b0) begin
      n_bad++; $display("FAIL push_done done=%b busy=%b we=%b fault=%b want 1/1/0/0", done, busy, mem_we, fault);
    end
    tick();
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL push_idle done=%b busy=%b want 0/0", done, busy);
    end
  endtask

  task automatic test_pop_wait();
    esp = 32'h0000_0FFC; mem_ready = 1'b0; pop_req = 1'b1;
    tick();
    pop_req = 1'b0;
    n_cmp++;
    if (mem_re !== 1'b1 || mem_addr !== 32'h0FFC || read_or_write !== 4'h0 || busy !== 1'b1) begin
      n_bad++; $display("FAIL pop_rd re=%b addr=%h rw=%h busy=%b want 1/00000ffc/0/1", mem_re, mem_addr, read_or_write, busy);
    end
    tick();
    n_cmp++;
    if (mem_re !== 1'b1) begin
      n_bad++; $display("FAIL pop_wait1 re=%b want 1", mem_re);
    end
    tick();
    n_cmp++;
    if (mem_re !== 1'b1 || done !== 1'b0) begin
      n_bad++; $display("FAIL pop_wait2 re=%b done=%b want 1/0", mem_re, done);
    end
    mem_ready = 1'b1; mem_rdata = 32'h1234_5678;
    tick();
    mem_ready = 1'b0; mem_rdata = 32'hFFFF_FFFF;
    n_cmp++;
    if (mem_re !== 1'b0 || pop_data !== 32'h1234_5678 || alu_result_bus !== 32'h1000 || read_or_write !== 4'h1) begin
      n_bad++; $display("FAIL pop_inc re=%b pd=%h alu=%h rw=%h want 0/12345678/00001000/1", mem_re, pop_data, alu_result_bus, read_or_write);
    end
    tick();
    n_cmp++;
    if (done !== 1'b1 || read_or_write !== 4'h0 || pop_data !== 32'h1234_5678) begin
      n_bad++; $display("FAIL pop_done done=%b rw=%h pd=%h want 1/0/12345678", done, read_or_write, pop_data);
    end
    tick();
  endtask

  task automatic test_both_req();
    logic saw_re, saw_we, saw_done;
    int   cycles;
    saw_re = 1'b0; saw_we = 1'b0; saw_done = 1'b0; cycles = 0;
    esp = 32'h0000_2000; push_data = 32'hA5A5_0001; mem_ready = 1'b1;
    push_req = 1'b1; pop_req = 1'b1;
    tick();
    push_req = 1'b0; pop_req = 1'b0;
    n_cmp++;
    if (alu_result_bus !== 32'h1FFC || read_or_write !== 4'h1) begin
      n_bad++; $display("FAIL both_dec alu=%h rw=%h want 00001ffc/1", alu_result_bus, read_or_write);
    end
    while (!saw_done && cycles < 8) begin
      if (mem_re) saw_re = 1'b1;
      if (mem_we) saw_we = 1'b1;
      tick();
      cycles++;
      if (done) saw_done = 1'b1;
    end
    n_cmp++;
    if (saw_re !== 1'b0 || saw_we !== 1'b1 || saw_done !== 1'b1) begin
      n_bad++; $display("FAIL both_seq re=%b we=%b done=%b want 0/1/1", saw_re, saw_we, saw_done);
    end
    tick();
  endtask

  task automatic test_wrap();
    esp = 32'h0; push_data = 32'h0000_0042; mem_ready = 1'b1; push_req = 1'b1;
    tick();
    push_req = 1'b0;
    n_cmp++;
    if (alu_result_bus !== 32'hFFFF_FFFC || read_or_write !== 4'h1 || fault !== 1'b0) begin
      n_bad++; $display("FAIL wrap_dec alu=%h rw=%h fault=%b want fffffffc/1/0", alu_result_bus, read_or_write, fault);
    end
    tick();
    n_cmp++;
    if (mem_addr !== 32'hFFFF_FFFC || mem_we !== 1'b1 || mem_wdata !== 32'h42) begin
      n_bad++; $display("FAIL wrap_wr addr=%h we=%b wdata=%h want fffffffc/1/00000042", mem_addr, mem_we, mem_wdata);
    end
    tick(); tick();
  endtask

  task automatic test_reset_mid();
    logic saw_rw;
    saw_rw = 1'b0;
    esp = 32'h0000_1000; push_data = 32'h1111_2222; mem_ready = 1'b0; push_req = 1'b1;
    tick();
    push_req = 1'b0;
    tick(); tick();
    n_cmp++;
    if (mem_we !== 1'b1) begin
      n_bad++; $display("FAIL midrst_pre we=%b want 1", mem_we);
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if (mem_we !== 1'b0 || read_or_write !== 4'h0 || busy !== 1'b0 || done !== 1'b0) begin
      n_bad++; $display("FAIL midrst_async we=%b rw=%h busy=%b done=%b want 0/0/0/0", mem_we, read_or_write, busy, done);
    end
    tick();
    reset = 1'b0; mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (read_or_write != 4'h0 || mem_we || busy) saw_rw = 1'b1;
    end
    n_cmp++;
    if (saw_rw !== 1'b0) begin
      n_bad++; $display("FAIL midrst_quiet activity=%b want 0", saw_rw);
    end
    esp = 32'h0000_3000; push_data = 32'h3333_4444; push_req = 1'b1;
    tick();
    push_req = 1'b0;
    n_cmp++;
    if (alu_result_bus !== 32'h2FFC || read_or_write !== 4'h1) begin
      n_bad++; $display("FAIL midrst_dec alu=%h rw=%h want 00002ffc/1", alu_result_bus, read_or_write);
    end
    tick();
    n_cmp++;
    if (mem_addr !== 32'h2FFC || mem_wdata !== 32'h3333_4444 || mem_we !== 1'b1) begin
      n_bad++; $display("FAIL midrst_wr addr=%h wdata=%h we=%b want 00002ffc/33334444/1", mem_addr, mem_wdata, mem_we);
    end
    tick();
    n_cmp++;
    if (done !== 1'b1) begin
      n_bad++; $display("FAIL midrst_done done=%b want 1", done);
    end
    tick();
  endtask

  task automatic test_bounds();
    logic saw_rw, saw_we;
    saw_rw = 1'b0; saw_we = 1'b0;
    esp = 32'h0000_0800; push_data = 32'h5555_6666; mem_ready = 1'b1; push_req = 1'b1;
    tick();
    push_req = 1'b0;
    if (read_or_write == 4'h1) saw_rw = 1'b1;
    if (mem_we) saw_we = 1'b1;
    n_cmp++;
    if (done !== 1'b1 || fault !== 1'b1 || busy !== 1'b1) begin
      n_bad++; $display("FAIL bounds_done done=%b fault=%b busy=%b want 1/1/1", done, fault, busy);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      if (read_or_write == 4'h1) saw_rw = 1'b1;
      if (mem_we) saw_we = 1'b1;
    end
    n_cmp++;
    if (saw_rw !== 1'b0 || saw_we !== 1'b0 || fault !== 1'b0) begin
      n_bad++; $display("FAIL bounds_quiet rw=%b we=%b fault=%b want 0/0/0", saw_rw, saw_we, fault);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_push();
    test_pop_wait();
    test_both_req();
`ifdef STACK_BOUNDS_CHECK_EN
    test_bounds();
`else
    test_wrap();
`endif
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/stack_op_sequencer.md
Name: stack_op_sequencer

Overview:
- Multi-cycle PUSH/POP sequencer; sits directly upstream of the ESP register.
- Receives push/pop requests from the decode/control stage.
- Computes the new stack pointer and drives it onto alu_result_bus with write code 4'h1 on read_or_write, which the ESP register latches.
- Performs the matching 32-bit memory write (push) or read (pop), with wait-state support.

Parameters:
- STACK_BASE, 32'h00001000, highest valid ESP; a pop at this value is an underflow (bounds feature only)
- STACK_LIMIT, 32'h00000800, lowest valid ESP; a push that would go below it is an overflow (bounds feature only)

Ports:
- clock_4  input  1  sequencer clock; all state updates on posedge
- reset  input  1  asynchronous, active-high reset
- esp  input  32  current stack pointer from the ESP register
- push_req  input  1  start PUSH; sampled only in IDLE
- pop_req  input  1  start POP; sampled only in IDLE
- push_data  input  32  value to push; captured when the request is accepted
- mem_rdata  input  32  memory read data; valid when mem_ready=1
- mem_ready  input  1  memory completes the current access this cycle
- mem_addr  output  32  memory address
- mem_wdata  output  32  memory write data
- mem_we  output  1  memory write strobe
- mem_re  output  1  memory read strobe
- alu_result_bus  output  32  new ESP value
- read_or_write  output  4  4'h1 = ESP write, 4'h0 = no ESP write
- pop_data  output  32  value popped
- busy  output  1  high from request accept until DONE inclusive
- done  output  1  one-cycle completion pulse
- fault  output  1  bounds violation (bounds feature only; otherwise tied 0)

Behaviour:
- All outputs are registered.
- Reset (asynchronous, any state):
  - state=IDLE.
  - mem_we=mem_re=0, read_or_write=4'h0, busy=done=fault=0.
  - mem_addr, mem_wdata, alu_result_bus, pop_data = 32'h0.
  - An in-flight memory access is abandoned; no ESP write occurs after reset.
- IDLE:
  - push_req=1 -> PUSH_DEC; capture push_data and esp; busy=1 next cycle.
  - If push_req and pop_req are both 1, push wins; pop is ignored and not acknowledged.
  - pop_req alone -> POP_RD; capture esp.
- PUSH_DEC (1 cycle):
  - alu_result_bus = captured_esp - 4, modulo 2^32 (esp=0 gives 32'hFFFFFFFC).
  - read_or_write = 4'h1 for exactly this cycle.
  - Next state: PUSH_WR.
- PUSH_WR:
  - mem_addr = captured_esp - 4, mem_wdata = captured push_data, mem_we = 1.
  - Held stable until a cycle with mem_ready=1; then -> DONE.
- POP_RD:
  - mem_addr = captured_esp, mem_re = 1, held until mem_ready=1.
  - On mem_ready: pop_data <= mem_rdata, then -> POP_INC.
- POP_INC (1 cycle):
  - alu_result_bus = captured_esp + 4, modulo 2^32 (32'hFFFFFFFC gives 0).
  - read_or_write = 4'h1.
  - Next state: DONE.
- DONE (1 cycle): done=1, busy=1, then -> IDLE. Requests are not sampled in DONE.
- read_or_write is 4'h0 in every state except PUSH_DEC and POP_INC.
- Latency with zero wait states: push accepted at edge N; DEC N+1, WR N+2, done N+3. Pop is the same: RD N+1, INC N+2, done N+3. Each mem_ready-low cycle adds 1.
- mem_ready is ignored outside PUSH_WR and POP_RD.
- pop_data holds its value until the next pop completes.

Optional Feature:
- Macro: STACK_BOUNDS_CHECK_EN.
- Defined: at accept, a push with esp-4 < STACK_LIMIT, or a pop with esp >= STACK_BASE, is a violation:
  - go directly to DONE; no ESP write, no memory access.
  - fault=1 for the same cycle as done.
- Undefined: no checks; fault is tied 0; wrap-around per the arithmetic rules above.

Test Plan:
- Reset, then esp=32'h1000, push_req with push_data=32'hDEADBEEF, mem_ready=1 -> read_or_write=4'h1 with alu_result_bus=32'h0FFC for 1 cycle; then mem_we with addr 32'h0FFC, wdata 32'hDEADBEEF; done 3 cycles after accept.
- esp=32'h0FFC, pop_req, mem_ready low 2 cycles then high with rdata=32'h12345678 -> mem_re held 3 cycles, pop_data=32'h12345678, alu_result_bus=32'h1000 with read_or_write=4'h1, done at accept+5.
- push_req and pop_req together, esp=32'h2000 -> push sequence only; alu_result_bus=32'h1FFC; no mem_re ever asserted.
- esp=32'h0, push (feature off) -> alu_result_bus=32'hFFFFFFFC, mem_addr=32'hFFFFFFFC.
- Reset asserted during PUSH_WR with mem_ready=0 -> mem_we=0 and read_or_write=4'h0 immediately; busy=0; next push starts cleanly.
- STACK_BOUNDS_CHECK_EN defined, esp=32'h800, push -> done=fault=1 one cycle after accept; read_or_write never 4'h1; mem_we never 1.
